mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, alongside the ALU; consumes the same forwarded operand pair A/B.
- Owns the HI/LO architectural registers and executes mult, multu, div, divu, mthi, mtlo.
- Exposes Busy so hazard logic stalls mf*/md instructions while an operation is in flight.

Parameters:
MULT_CYCLES, 5, Busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, Busy cycles for div/divu (>=1)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
A  input  32  operand rs (forwarded)
B  input  32  operand rt (forwarded)
MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
Start  input  1  launch strobe for MDOp 1..4
Busy  output  1  operation in flight
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (async, any time incl. mid-operation): HI=0, LO=0, Busy=0, counter=0, pending result discarded.
- Idle: Busy=0, counter=0.
- Launch edge, Start=1 && Busy=0 && MDOp in 1..4:
  - latch result internally.
  - counter <= MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - Busy <= 1.
  - HI/LO unchanged.
- Busy edges: counter decrements each rising edge. On the edge where counter goes 1->0, commit result to HI/LO and Busy <= 0.
  - Busy is high for exactly N cycles after the launch edge.
  - New HI/LO are visible in the cycle Busy is first 0.
- Start while Busy=1: ignored; no restart, no operand capture.
- Start=1 with MDOp in {0,5,6,7}: no launch.
- mthi/mtlo (MDOp 5/6), Busy=0: HI (resp. LO) <= A at the edge. Single cycle, Busy stays 0, Start ignored.
- mthi/mtlo with Busy=1: ignored. Upstream stall logic must prevent this case.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 -> 64.
  - div: signed, quotient truncates toward zero. LO=quotient, HI=remainder, remainder sign follows dividend.
  - divu: unsigned.
  - 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B=0, ops 3/4): Busy still runs DIV_CYCLES; on completion HI and LO remain unchanged.
- Outputs are registered. HI/LO change only on commit, mthi/mtlo, or reset.
- Result computation may be combinational at launch or iterative, but must be committed exactly at the specified edge.

Test Plan:
- Signed mult: reset, then A=0xFFFFFFFD, B=5, MDOp=1, Start=1 for one cycle -> Busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1, Busy=0.
- Unsigned mult: A=B=0xFFFFFFFF, MDOp=2 -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- Signed div: A=0xFFFFFFF9 (-7), B=2, MDOp=3 -> Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Follow with divu A=7, B=2 -> LO=3, HI=1.
- Divide by zero: preload HI=0x11 via mthi, LO=0x22 via mtlo; then div A=9, B=0 -> Busy 10 cycles; HI=0x11, LO=0x22 afterwards.
- Start while busy: launch mult 2*3; at cycle 2 of Busy, Start with div 8/2 -> div ignored, Busy drops after exactly 5 cycles, HI=0, LO=6.
- Reset mid-operation: launch div 100/7; assert reset asynchronously at cycle 4 -> Busy, HI, LO go 0 immediately; after release, no commit occurs. Then mtlo A=0x5A -> LO=0x5A the next cycle, Busy stays 0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit; owns the HI/LO registers (mult, multu, div, divu, mthi, mtlo).
// Latency: Busy is high for MULT_CYCLES or DIV_CYCLES cycles after launch; HI/LO update on the edge Busy falls.
// Backpressure: no handshake; Start and mthi/mtlo are ignored while Busy=1, so hazard logic must stall on Busy.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   A, B            forwarded rs/rt operands
//   MDOp, Start     operation select (1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo) and launch strobe
//   Busy, HI, LO    registered busy flag and architectural HI/LO
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic          res_wr_q, res_wr_d;  // cleared for divide-by-zero so HI/LO are left alone

  // Results are computed combinationally from the operands present at launch.
  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow case,
  // which falls out naturally as quotient 0x80000000, remainder 0.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, bs_safe, bu_safe;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  assign a_neg   = A[31];
  assign b_neg   = B[31];
  assign a_mag   = a_neg ? (32'd0 - A) : A;
  assign b_mag   = b_neg ? (32'd0 - B) : B;
  // Divisor forced non-zero only to keep the divider defined; the result is discarded when B=0.
  assign bs_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign bu_safe = (B == 32'd0) ? 32'd1 : B;
  assign q_mag   = a_mag / bs_safe;
  assign r_mag   = a_mag % bs_safe;
  assign q_s     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign r_s     = a_neg ? (32'd0 - r_mag) : r_mag;
  assign q_u     = A / bu_safe;
  assign r_u     = A % bu_safe;

  logic launch;
  assign launch = Start && !busy_q &&
                  (MDOp == OP_MULT || MDOp == OP_MULTU || MDOp == OP_DIV || MDOp == OP_DIVU);

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        if (res_wr_q) begin
          hi_d = res_hi_q;
          lo_d = res_lo_q;
        end
      end
    end else if (launch) begin
      busy_d   = 1'b1;
      res_wr_d = 1'b1;
      case (MDOp)
        OP_MULT: begin
          cnt_d    = CW'(MULT_CYCLES);
          res_hi_d = prod_s[63:32];
          res_lo_d = prod_s[31:0];
        end
        OP_MULTU: begin
          cnt_d    = CW'(MULT_CYCLES);
          res_hi_d = prod_u[63:32];
          res_lo_d = prod_u[31:0];
        end
        OP_DIV: begin
          cnt_d    = CW'(DIV_CYCLES);
          res_hi_d = r_s;
          res_lo_d = q_s;
          res_wr_d = (B != 32'd0);
        end
        default: begin
          cnt_d    = CW'(DIV_CYCLES);
          res_hi_d = r_u;
          res_lo_d = q_u;
          res_wr_d = (B != 32'd0);
        end
      endcase
    end else if (MDOp == OP_MTHI) begin
      hi_d = A;
    end else if (MDOp == OP_MTLO) begin
      lo_d = A;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_wr_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed scenarios then randomized ops against a reference model.
// Latency: model commits results a fixed number of cycles after each launch.
// Backpressure: model drops launches and mthi/mtlo issued while busy.
module tb_mul_div_unit;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  mul_div_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp), .Start(Start),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  string ctx = "init";

  // Reference model: architectural HI/LO plus a pending result and the cycle it lands.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          m_busy, p_wr;
  int          cyc, done_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h (cycle %0d)", ctx, tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_busy = 0; p_wr = 0;
  endtask

  // Called just after each rising edge with the inputs that were sampled on it.
  task automatic model_edge();
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    cyc++;
    sa = longint'($signed(A));
    sb = longint'($signed(B));
    ua = {32'd0, A};
    ub = {32'd0, B};
    if (m_busy) begin
      if (cyc == done_cyc) begin
        m_busy = 0;
        if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
      end
    end else if (Start && MDOp >= 3'd1 && MDOp <= 3'd4) begin
      m_busy = 1;
      p_wr = 1;
      case (MDOp)
        3'd1: begin sq = sa * sb; p_hi = sq[63:32]; p_lo = sq[31:0]; done_cyc = cyc + NM; end
        3'd2: begin up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0]; done_cyc = cyc + NM; end
        3'd3: begin
          done_cyc = cyc + ND;
          if (B == 0) p_wr = 0;
          else begin sq = sa / sb; sr = sa % sb; p_lo = sq[31:0]; p_hi = sr[31:0]; end
        end
        default: begin
          done_cyc = cyc + ND;
          if (B == 0) p_wr = 0;
          else begin up = ua / ub; p_lo = up[31:0]; up = ua % ub; p_hi = up[31:0]; end
        end
      endcase
    end else if (MDOp == 3'd5) begin
      m_hi = A;
    end else if (MDOp == 3'd6) begin
      m_lo = A;
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input logic st);
    A = a; B = b; MDOp = op; Start = st;
    @(posedge clk);
    model_edge();
    #1;
    check("busy", {63'd0, Busy}, {63'd0, m_busy});
    check("hi", {32'd0, HI}, {32'd0, m_hi});
    check("lo", {32'd0, LO}, {32'd0, m_lo});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'd0, 32'd0, 3'd0, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; A = 0; B = 0; MDOp = 0; Start = 0; cyc = 0; done_cyc = 0;
    model_reset();
    #12;
    ctx = "reset";
    check("busy", {63'd0, Busy}, 64'd0);
    check("hi", {32'd0, HI}, 64'd0);
    check("lo", {32'd0, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    ctx = "mult";
    step(32'hFFFF_FFFD, 32'd5, 3'd1, 1'b1);
    idle(NM);
    check("hi_const", {32'd0, HI}, 64'hFFFF_FFFF);
    check("lo_const", {32'd0, LO}, 64'hFFFF_FFF1);

    ctx = "multu";
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 1'b1);
    idle(NM);
    check("hi_const", {32'd0, HI}, 64'hFFFF_FFFE);
    check("lo_const", {32'd0, LO}, 64'h0000_0001);

    ctx = "div";
    step(32'hFFFF_FFF9, 32'd2, 3'd3, 1'b1);
    idle(ND);
    check("hi_const", {32'd0, HI}, 64'hFFFF_FFFF);
    check("lo_const", {32'd0, LO}, 64'hFFFF_FFFD);

    ctx = "divu";
    step(32'd7, 32'd2, 3'd4, 1'b1);
    idle(ND);
    check("hi_const", {32'd0, HI}, 64'd1);
    check("lo_const", {32'd0, LO}, 64'd3);

    ctx = "div_ovf";
    step(32'h8000_0000, 32'hFFFF_FFFF, 3'd3, 1'b1);
    idle(ND);
    check("hi_const", {32'd0, HI}, 64'd0);
    check("lo_const", {32'd0, LO}, 64'h8000_0000);

    ctx = "divzero";
    step(32'h11, 32'd0, 3'd5, 1'b1);
    step(32'h22, 32'd0, 3'd6, 1'b0);
    step(32'd9, 32'd0, 3'd3, 1'b1);
    idle(ND + 1);
    check("hi_const", {32'd0, HI}, 64'h11);
    check("lo_const", {32'd0, LO}, 64'h22);

    ctx = "start_busy";
    step(32'd2, 32'd3, 3'd1, 1'b1);
    idle(1);
    step(32'd8, 32'd2, 3'd3, 1'b1);
    step(32'h77, 32'd0, 3'd5, 1'b0);
    idle(NM - 3);
    check("busy_const", {63'd0, Busy}, 64'd0);
    check("hi_const", {32'd0, HI}, 64'd0);
    check("lo_const", {32'd0, LO}, 64'd6);
    idle(ND);

    ctx = "reset_mid";
    step(32'd100, 32'd7, 3'd3, 1'b1);
    idle(3);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("busy", {63'd0, Busy}, 64'd0);
    check("hi", {32'd0, HI}, 64'd0);
    check("lo", {32'd0, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(ND + 2);
    step(32'h5A, 32'd0, 3'd6, 1'b0);
    check("lo_const", {32'd0, LO}, 64'h5A);

    ctx = "random";
    for (int i = 0; i < 3000; i++) begin
      step(pick(), pick(), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end
    idle(ND + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
